// File: rtl/id_stage.sv
// Purpose     : RV32I decode stage; forms a registered ALU command from an instruction word and its operands.
// Latency     : 1 cycle from the accept edge to out_valid.
// Backpressure: single-entry output register; in_ready drops while a held command is not consumed or flush is high.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready/in_inst/in_pc   instruction handshake and payload
//   rs1_addr/rs2_addr             register-file read addresses (combinational from in_inst)
//   rs1_data/rs2_data             register-file read data, sampled on the accept edge
//   flush                         drop held and incoming instruction
//   out_valid/out_ready           command handshake
//   op, op_imm, funct3, funct7, a, b   ALU command
//   rd, rd_we, pc, illegal        destination, writeback enable, PC, bad-encoding flag
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [31:0]     in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            op,
    output logic            op_imm,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic [31:0]     pc,
    output logic            illegal
);

    // Opcodes
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // ALU funct3 encodings
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SL  = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]      w_opcode;
    logic [2:0]      w_inst_f3;
    logic [6:0]      w_inst_f7;
    logic [4:0]      w_rd;
    logic            w_op;
    logic            w_op_imm;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_illegal;
    logic            w_rd_we;
    logic            w_accept;

    logic            r_out_valid;
    logic            r_op;
    logic            r_op_imm;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    logic [31:0]     r_pc;
    logic            r_illegal;

    assign w_opcode  = in_inst[6:0];
    assign w_inst_f3 = in_inst[14:12];
    assign w_inst_f7 = in_inst[31:25];
    assign w_rd      = in_inst[11:7];

    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    // Decode
    always_comb begin
        w_op      = 1'b0;
        w_op_imm  = 1'b0;
        w_funct3  = F3_ADD;
        w_funct7  = F7_ZERO;
        w_a       = '0;
        w_b       = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_op      = 1'b1;
                w_a       = rs1_data;
                w_b       = rs2_data;
                w_funct3  = w_inst_f3;
                w_funct7  = w_inst_f7;
                // The alternate funct7 only has meaning for SUB and SRA.
                w_illegal = !((w_inst_f7 == F7_ZERO) ||
                              ((w_inst_f7 == F7_ALT) &&
                               ((w_inst_f3 == F3_ADD) || (w_inst_f3 == F3_SR))));
            end
            OPC_OPIMM: begin
                w_op_imm = 1'b1;
                w_a      = rs1_data;
                w_funct3 = w_inst_f3;
                if ((w_inst_f3 == F3_SL) || (w_inst_f3 == F3_SR)) begin
                    w_b       = {{(XLEN-5){1'b0}}, in_inst[24:20]};
                    w_funct7  = w_inst_f7;
                    w_illegal = (w_inst_f3 == F3_SL) ? (w_inst_f7 != F7_ZERO)
                                                     : !((w_inst_f7 == F7_ZERO) || (w_inst_f7 == F7_ALT));
                end else begin
                    // Upper immediate bits must not leak into funct7, or ADDI
                    // with a negative immediate would turn into a subtract.
                    w_b      = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                    w_funct7 = F7_ZERO;
                end
            end
            OPC_LUI: begin
                w_op_imm = 1'b1;
                w_b      = {in_inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                w_op_imm = 1'b1;
                w_a      = in_pc;
                w_b      = {in_inst[31:12], 12'b0};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_rd_we  = !w_illegal && (w_rd != 5'd0);
    assign in_ready = !flush && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Valid bit: flush wins over both accept and consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Payload only changes on accept, so it is bit-stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 1'b0;
            r_op_imm  <= 1'b0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_rd_we   <= 1'b0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_op      <= w_op;
            r_op_imm  <= w_op_imm;
            r_funct3  <= w_funct3;
            r_funct7  <= w_funct7;
            r_a       <= w_a;
            r_b       <= w_b;
            r_rd      <= w_rd;
            r_rd_we   <= w_rd_we;
            r_pc      <= in_pc;
            r_illegal <= w_illegal;
        end
    end

    assign out_valid = r_out_valid;
    assign op        = r_op;
    assign op_imm    = r_op_imm;
    assign funct3    = r_funct3;
    assign funct7    = r_funct7;
    assign a         = r_a;
    assign b         = r_b;
    assign rd        = r_rd;
    assign rd_we     = r_rd_we;
    assign pc        = r_pc;
    assign illegal   = r_illegal;

endmodule
